y_mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit: the sequential successor to the combinational `yAlu`, adding the RV32M operation set on a `WIDTH`-bit datapath. Sits in the EX stage beside `yAlu` and takes the same `rd1`/`rd2` operands. It stalls the pipeline through a start/busy/done handshake. Radix-2 iterative: one bit per cycle, fixed latency independent of operand values.

---
 rtl/y_mdu_pkg.sv | 26 ++
 rtl/y_addsub.sv | 16 +
 rtl/y_mdu.sv | 155 +++++++++++++++
 tb/tb_y_mdu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/y_mdu_pkg.sv
// Shared types for the y_mdu multiply/divide unit: RV32M funct3 encoding,
// FSM states and a small decode helper.
package y_mdu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   function automatic logic is_div(input op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/y_addsub.sv
// Plain N-bit adder/subtractor shared by the multiply accumulate and the
// restoring-divide trial subtraction.
module y_addsub #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] y
);

   always_comb begin
      y = sub ? (a - b) : (a + b);
   end

endmodule

// File: rtl/y_mdu.sv
// Radix-2 iterative RV32M multiply/divide unit with start/busy/done handshake.
// Operands are reduced to magnitudes on acceptance; signs are restored in FIX.
import y_mdu_pkg::*;

module y_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             kill,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   // Handshake: start is taken only in IDLE; busy covers CALC and FIX;
   // done is a one-cycle pulse registered on the FIX exit, when busy is already low.
   state_e           state, state_nx;
   logic [CW-1:0]    cnt;
   op_e              op_q;
   logic [WIDTH-1:0] a_q, opnd, acc_hi, acc_lo;
   logic             neg, rneg, dz, ovf;

   op_e              op_in;
   logic             a_sgn, b_sgn, signed_div;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             accept, finish;
   logic [WIDTH:0]   add_x, add_z, add_y, mul_step;
   logic             add_sub;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix, res_nx;

   assign op_in      = op_e'(op);
   assign accept     = (state == S_IDLE) && start;
   assign finish     = (state == S_FIX) && !kill;
   assign busy       = (state != S_IDLE);
   assign dbg_state  = state;
   assign signed_div = (op_in == OP_DIV) || (op_in == OP_REM);

   // Operand magnitudes: MULHSU treats only rs1 as signed.
   always_comb begin
      a_sgn = ((op_in == OP_MULH) || (op_in == OP_MULHSU) || signed_div) && a[WIDTH-1];
      b_sgn = ((op_in == OP_MULH) || signed_div) && b[WIDTH-1];
      a_mag = a_sgn ? -a : a;
      b_mag = b_sgn ? -b : b;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_CALC;
         S_CALC:  if (kill) state_nx = S_IDLE;
                  else if (cnt == '0) state_nx = S_FIX;
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Divide feeds the shifted partial remainder; multiply feeds the high half.
   always_comb begin
      add_z = {1'b0, opnd};
      if (is_div(op_q)) begin
         add_x   = {acc_hi, acc_lo[WIDTH-1]};
         add_sub = 1'b1;
      end else begin
         add_x   = {1'b0, acc_hi};
         add_sub = 1'b0;
      end
      mul_step = acc_lo[0] ? add_y : {1'b0, acc_hi};
   end

   y_addsub #(.N(WIDTH + 1)) u_addsub (
      .a   (add_x),
      .b   (add_z),
      .sub (add_sub),
      .y   (add_y)
   );

   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = neg ? -prod : prod;
      quot_fix = neg ? -acc_lo : acc_lo;
      rem_fix  = rneg ? -acc_hi : acc_hi;
      res_nx   = '0;
      case (op_q)
         OP_MUL:                        res_nx = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  res_nx = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:               res_nx = dz ? '1 : (ovf ? a_q : quot_fix);
         OP_REM, OP_REMU:               res_nx = dz ? a_q : (ovf ? '0 : rem_fix);
         default:                       res_nx = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         op_q   <= OP_MUL;
         a_q    <= '0;
         opnd   <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg    <= 1'b0;
         rneg   <= 1'b0;
         dz     <= 1'b0;
         ovf    <= 1'b0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         if (accept) begin
            op_q   <= op_in;
            a_q    <= a;
            neg    <= a_sgn ^ b_sgn;
            rneg   <= a_sgn;
            dz     <= (b == '0);
            ovf    <= signed_div && (a == MOST_NEG) && (b == '1);
            cnt    <= CNT_LAST;
            acc_hi <= '0;
            if (is_div(op_in)) begin
               opnd   <= b_mag;
               acc_lo <= a_mag;
            end else begin
               opnd   <= a_mag;
               acc_lo <= b_mag;
            end
         end else if (state == S_CALC) begin
            cnt <= cnt - CW'(1);
            if (is_div(op_q)) begin
               // Restoring step: keep the difference only when it stayed non-negative.
               acc_hi <= add_y[WIDTH] ? add_x[WIDTH-1:0] : add_y[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], ~add_y[WIDTH]};
            end else begin
               acc_hi <= mul_step[WIDTH:1];
               acc_lo <= {mul_step[0], acc_lo[WIDTH-1:1]};
            end
         end
         if (finish) result <= res_nx;
         done <= finish;
      end
   end

endmodule

// File: tb/tb_y_mdu.sv
// Self-checking bench for y_mdu: directed RV32M cases, control scenarios
// (kill, ignored start, async reset, back-to-back) and random operations.
module tb_y_mdu;
   import y_mdu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         kill = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done;
   logic [W-1:0] result;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   y_mdu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .kill      (kill),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .dbg_state (dbg_state)
   );

   int           n_checks = 0;
   int           n_pass = 0;
   int           n_done = 0;
   int           n_overlap = 0;
   int           n_double = 0;
   logic         prev_done = 1'b0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_res = '0;
   logic [W-1:0] mon_e;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0]  p;
      logic signed [W-1:0] sx, sy;
      logic            ovf;
      sx  = x;
      sy  = y;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      p   = '0;
      case (o)
         3'b000: begin p = {32'b0, x} * {32'b0, y}; return p[W-1:0]; end
         3'b001: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return p[2*W-1:W]; end
         3'b010: begin p = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return p[2*W-1:W]; end
         3'b011: begin p = {32'b0, x} * {32'b0, y}; return p[2*W-1:W]; end
         3'b100: return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : W'(sx / sy));
         3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'b110: return (y == 0) ? x : (ovf ? 32'h0 : W'(sx % sy));
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   // Result scoreboard and handshake invariants, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (busy && done) n_overlap++;
         if (done && prev_done) n_double++;
         prev_done = done;
         if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
               check("spurious_done", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("result", result, mon_e);
               last_res = mon_e;
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke, input bit kill_idle);
      int lat, busy_n;
      lat    = 0;
      busy_n = 0;
      op     = o;
      a      = x;
      b      = y;
      start  = 1'b1;
      kill   = kill_idle;
      exp_q.push_back(model(o, x, y));
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0;
            kill  = 1'b0;
            op    = 3'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
         end
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_n++;
         if (poke && i == 6) begin
            start = 1'b1;
            op    = 3'($urandom);
            a     = W'($urandom);
         end
         if (poke && i == 7) start = 1'b0;
      end
      check("latency", W'(lat), W'(W + 2));
      check("busy_cycles", W'(busy_n), W'(W + 1));
   endtask

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   task automatic kill_test();
      logic [W-1:0] prev;
      int           dn;
      @(negedge clk);
      prev  = last_res;
      dn    = n_done;
      op    = 3'b100;
      a     = W'($urandom);
      b     = W'($urandom);
      start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      kill  = 1'b1;
      start = 1'b1;
      @(negedge clk);
      kill  = 1'b0;
      start = 1'b0;
      check("kill_busy", W'(busy), '0);
      check("kill_result", result, prev);
      repeat (W + 5) @(negedge clk);
      check("kill_no_done", W'(n_done), W'(dn));
   endtask

   task automatic reset_test();
      int dn;
      @(negedge clk);
      op    = 3'b011;
      a     = 32'hDEAD_BEEF;
      b     = 32'h1234_5678;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", W'(busy), '0);
      check("rst_mid_done", W'(done), '0);
      check("rst_mid_result", result, '0);
      check("rst_mid_state", W'(dbg_state), '0);
      @(negedge clk);
      rst_n    = 1'b1;
      last_res = '0;
      dn       = n_done;
      repeat (W + 5) @(negedge clk);
      check("rst_no_done", W'(n_done), W'(dn));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", W'(busy), '0);
      check("reset_done", W'(done), '0);
      check("reset_result", result, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases, issued back-to-back in each done cycle.
      issue(3'b000, 32'd7,          32'd6,          1'b0, 1'b0);
      issue(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0);
      issue(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0);
      issue(3'b010, 32'hFFFF_FFFF,  32'd2,          1'b0, 1'b0);
      issue(3'b100, 32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0);
      issue(3'b110, 32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0);
      issue(3'b101, 32'd100,        32'd3,          1'b1, 1'b0);
      issue(3'b111, 32'd100,        32'd3,          1'b0, 1'b1);
      issue(3'b101, 32'd100,        32'd0,          1'b0, 1'b0);
      issue(3'b111, 32'd100,        32'd0,          1'b0, 1'b0);
      issue(3'b100, 32'd100,        32'd0,          1'b0, 1'b0);
      issue(3'b110, 32'd100,        32'd0,          1'b0, 1'b0);
      issue(3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0);
      issue(3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0);

      kill_test();
      reset_test();

      for (int n = 0; n < 16; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue(3'($urandom), rnd_val(), rnd_val(), n[0], n[1] & n[2]);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", W'(exp_q.size()), '0);
      check("busy_done_overlap", W'(n_overlap), '0);
      check("double_done", W'(n_double), '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
